// File: rtl/signed_bin2bcd_seq.sv
// signed_bin2bcd_seq
// Sequential binary to BCD converter with sign extraction. A DATA_W-bit word,
// two's complement when SIGNED = 1, is split into a sign flag and a magnitude.
// The magnitude is converted to DIGITS packed BCD digits by a serial
// double-dabble engine that handles one bit per clock. The result feeds the
// 7-segment digit decoders.
//
// Optional feature, macro BCD_ZERO_BLANK_EN:
//   Adds the o_blank output. Bit k (k >= 1) is set when digit k and every
//   higher digit are zero, so the decoders can suppress leading zeros.
//   Bit 0 is always clear, so a zero result still shows a single "0".
//   When the macro is undefined the port and its logic do not exist.
//
// Handshake (valid/ready): a word transfers on a rising edge where both
// i_valid and o_ready are 1. i_data is sampled only on that edge. While
// o_ready is 0, i_valid is ignored and nothing is queued. The producer may
// hold i_valid high for as long as it likes. o_done is a single-cycle pulse
// that marks o_bcd/o_neg (and o_blank) as freshly updated. There is no
// backpressure on the result side.

module signed_bin2bcd_seq #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_valid,
  input  logic [DATA_W-1:0]     i_data,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_neg,
  output logic [4*DIGITS-1:0]   o_bcd
`ifdef BCD_ZERO_BLANK_EN
  ,
  output logic [DIGITS-1:0]     o_blank
`endif
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------

  // 10^n evaluated at 128 bits, wide enough for any DIGITS that could matter.
  function automatic logic [127:0] pow10(input int n);
    logic [127:0] p;
    p = 128'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 128'd10;
    end
    return p;
  endfunction

  localparam logic [127:0] DEC_RANGE = pow10(DIGITS);
  localparam logic [127:0] BIN_RANGE = 128'd1 << DATA_W;

  generate
    if (DATA_W < 2 || DATA_W > 32) begin : g_width_err
      $error("signed_bin2bcd_seq: DATA_W must be in 2..32");
    end
    if (DIGITS < 1) begin : g_digits_err
      $error("signed_bin2bcd_seq: DIGITS must be at least 1");
    end
    if (DEC_RANGE < BIN_RANGE) begin : g_range_err
      $error("signed_bin2bcd_seq: DIGITS too small to hold 2^DATA_W");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Types, constants and state
  // ---------------------------------------------------------------------------

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // state_q is the single point of truth for the FSM and is left easy to
  // probe hierarchically (u_dut.state_q).
  state_t                 state_q;
  state_t                 state_d;

  logic [DATA_W-1:0]      bin_q;       // binary bits still to be shifted in
  logic [4*DIGITS-1:0]    scratch_q;   // BCD digits being built up
  logic [CNT_W-1:0]       cnt_q;       // number of shifts already done
  logic                   neg_q;       // sign of the word in flight

  logic                   accept;      // handshake fires on this edge
  logic                   finish;      // last shift happens on this edge

  logic                   in_neg;
  logic [DATA_W-1:0]      in_mag;

  logic [4*DIGITS-1:0]    scratch_adj; // digits after the add-3 correction
  logic [4*DIGITS-1:0]    scratch_sh;  // digits after the shift
  logic [DATA_W-1:0]      bin_sh;      // binary word after the shift

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave IDLE on a handshake and return after the last shift.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_valid)             state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == CNT_LAST)   state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ready in IDLE, plus the accept and finish strobes.
  always_comb begin
    o_ready = (state_q == S_IDLE);
    accept  = (state_q == S_IDLE) && i_valid;
    finish  = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Sign split. The negation stays at DATA_W bits, so the most negative word
  // maps to 2^(DATA_W-1) as an unsigned magnitude without overflowing.
  always_comb begin
    in_neg = SIGNED && i_data[DATA_W-1];
    in_mag = in_neg ? (~i_data + DATA_W'(1)) : i_data;
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift
  // {scratch, bin} left by one bit.
  always_comb begin
    scratch_adj = scratch_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scratch_q[4*k +: 4] >= 4'd5) begin
        scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
      end
    end
    scratch_sh = {scratch_adj[4*DIGITS-2:0], bin_q[DATA_W-1]};
    bin_sh     = {bin_q[DATA_W-2:0], 1'b0};
  end

  // Working registers: load on accept, step once per clock while shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
    end else if (accept) begin
      bin_q     <= in_mag;
      scratch_q <= '0;
      cnt_q     <= '0;
      neg_q     <= in_neg;
    end else if (state_q == S_SHIFT) begin
      bin_q     <= bin_sh;
      scratch_q <= scratch_sh;
      cnt_q     <= cnt_q + CNT_W'(1);
    end
  end

  // Result registers: updated only on the final shift. They hold their value
  // through the next conversion, so the display does not flicker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_done <= 1'b0;
      o_neg  <= 1'b0;
      o_bcd  <= '0;
    end else begin
      o_done <= finish;
      if (finish) begin
        o_neg <= neg_q;
        o_bcd <= scratch_sh;
      end
    end
  end

`ifdef BCD_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_d;
  logic              hi_zero;

  // Leading-zero mask: walk down from the top digit and stop blanking at the
  // first nonzero digit. Digit 0 is never blanked.
  always_comb begin
    blank_d = '0;
    hi_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hi_zero    = hi_zero && (scratch_sh[4*k +: 4] == 4'd0);
      blank_d[k] = hi_zero;
    end
  end

  // Blank mask register, updated together with o_bcd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_blank <= '0;
    end else if (finish) begin
      o_blank <= blank_d;
    end
  end
`endif

endmodule

// File: tb/tb_signed_bin2bcd_seq.sv
// Bench for signed_bin2bcd_seq. It drives three instances:
//   u_dut  - defaults (DATA_W=8, DIGITS=3, SIGNED=1): vector table, back-to-back
//            transfer, ignored valid during a conversion, asynchronous reset
//            in the middle of a conversion
//   u_uns  - SIGNED=0
//   u_wide - DATA_W=16, DIGITS=5
// Define BCD_ZERO_BLANK_EN to also check the o_blank outputs.

module tb_signed_bin2bcd_seq;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic        i_valid;
  logic [7:0]  i_data;
  logic        o_ready, o_done, o_neg;
  logic [11:0] o_bcd;

  logic        u_valid;
  logic [7:0]  u_data;
  logic        u_ready, u_done, u_neg;
  logic [11:0] u_bcd;

  logic        w_valid;
  logic [15:0] w_data;
  logic        w_ready, w_done, w_neg;
  logic [19:0] w_bcd;

`ifdef BCD_ZERO_BLANK_EN
  logic [2:0]  o_blank;
  logic [2:0]  u_blank;
  logic [4:0]  w_blank;
`endif

  signed_bin2bcd_seq #(.DATA_W(8), .DIGITS(3), .SIGNED(1'b1)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_done  (o_done),
    .o_neg   (o_neg),
    .o_bcd   (o_bcd)
`ifdef BCD_ZERO_BLANK_EN
    ,
    .o_blank (o_blank)
`endif
  );

  signed_bin2bcd_seq #(.DATA_W(8), .DIGITS(3), .SIGNED(1'b0)) u_uns (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (u_valid),
    .i_data  (u_data),
    .o_ready (u_ready),
    .o_done  (u_done),
    .o_neg   (u_neg),
    .o_bcd   (u_bcd)
`ifdef BCD_ZERO_BLANK_EN
    ,
    .o_blank (u_blank)
`endif
  );

  signed_bin2bcd_seq #(.DATA_W(16), .DIGITS(5), .SIGNED(1'b1)) u_wide (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_valid),
    .i_data  (w_data),
    .o_ready (w_ready),
    .o_done  (w_done),
    .o_neg   (w_neg),
    .o_bcd   (w_bcd)
`ifdef BCD_ZERO_BLANK_EN
    ,
    .o_blank (w_blank)
`endif
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping and compare helper
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

`ifdef BCD_ZERO_BLANK_EN
  // Independent leading-zero model for three digits.
  function automatic logic [2:0] blank_of(input logic [11:0] b);
    logic [2:0] r;
    r[0] = 1'b0;
    r[2] = (b[11:8] == 4'd0);
    r[1] = r[2] && (b[7:4] == 4'd0);
    return r;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Scoreboard for u_dut: {neg, bcd} pushed on each accepted word
  // ---------------------------------------------------------------------------
  logic [12:0] exp_q[$];
  logic [11:0] last_bcd = 12'h000;
  logic        last_neg = 1'b0;

  // On every done pulse, pop the oldest expected result and compare.
  always @(negedge clk) begin
    if (rst_n && o_done) begin
      check("done_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("bcd", 64'(o_bcd), 64'(e[11:0]));
        check("neg", 64'(o_neg), 64'(e[12]));
`ifdef BCD_ZERO_BLANK_EN
        check("blank", 64'(o_blank), 64'(blank_of(e[11:0])));
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------

  // Wait for o_done on u_dut. Returns how many negedges passed after the
  // first one that followed the accept edge (the expected count is 8).
  task automatic wait_done(output int k, output bit bad_ready, output bit bad_hold);
    k = 0;
    bad_ready = 1'b0;
    bad_hold = 1'b0;
    while (!o_done && k < 40) begin
      if (o_ready !== 1'b0) bad_ready = 1'b1;
      if (o_bcd !== last_bcd || o_neg !== last_neg) bad_hold = 1'b1;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_vec(input logic [7:0] data, input logic [11:0] bcd, input logic neg);
    int k;
    bit bad_ready, bad_hold;
    @(negedge clk);
    check("ready_idle", 64'(o_ready), 64'd1);
    i_valid = 1'b1;
    i_data  = data;
    exp_q.push_back({neg, bcd});
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    i_data  = 8'($urandom_range(0, 255));
    wait_done(k, bad_ready, bad_hold);
    check("latency", 64'(k), 64'd8);
    check("ready_low_shift", 64'(bad_ready), 64'd0);
    check("hold_during_shift", 64'(bad_hold), 64'd0);
    check("ready_in_done", 64'(o_ready), 64'd1);
    last_bcd = bcd;
    last_neg = neg;
  endtask

  task automatic run_uns(input logic [7:0] data, input logic [11:0] bcd);
    int k;
    @(negedge clk);
    u_valid = 1'b1;
    u_data  = data;
    @(posedge clk);
    @(negedge clk);
    u_valid = 1'b0;
    k = 0;
    while (!u_done && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("uns_latency", 64'(k), 64'd8);
    check("uns_bcd", 64'(u_bcd), 64'(bcd));
    check("uns_neg", 64'(u_neg), 64'd0);
`ifdef BCD_ZERO_BLANK_EN
    check("uns_blank", 64'(u_blank), 64'(blank_of(bcd)));
`endif
  endtask

  task automatic run_wide(input logic [15:0] data, input logic [19:0] bcd, input logic neg);
    int k;
    @(negedge clk);
    w_valid = 1'b1;
    w_data  = data;
    @(posedge clk);
    @(negedge clk);
    w_valid = 1'b0;
    k = 0;
    while (!w_done && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("wide_latency", 64'(k), 64'd16);
    check("wide_bcd", 64'(w_bcd), 64'(bcd));
    check("wide_neg", 64'(w_neg), 64'(neg));
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0]  data;
    logic [11:0] bcd;
    logic        neg;
  } vec_t;

  vec_t vecs[9];

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int  k;
    bit  bad_ready, bad_hold, seen;

    vecs[0] = '{8'h7F, 12'h127, 1'b0};
    vecs[1] = '{8'h80, 12'h128, 1'b1};
    vecs[2] = '{8'hFF, 12'h001, 1'b1};
    vecs[3] = '{8'h00, 12'h000, 1'b0};
    vecs[4] = '{8'h07, 12'h007, 1'b0};
    vecs[5] = '{8'h64, 12'h100, 1'b0};
    vecs[6] = '{8'h9C, 12'h100, 1'b1};
    vecs[7] = '{8'hC8, 12'h056, 1'b1};
    vecs[8] = '{8'h0A, 12'h010, 1'b0};

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = 8'h00;
    u_valid = 1'b0;
    u_data  = 8'h00;
    w_valid = 1'b0;
    w_data  = 16'h0000;

    // Reset values, before any clock edge.
    #2;
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_neg", 64'(o_neg), 64'd0);
    check("rst_bcd", 64'(o_bcd), 64'd0);
`ifdef BCD_ZERO_BLANK_EN
    check("rst_blank", 64'(o_blank), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven conversions on the default instance.
    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i].data, vecs[i].bcd, vecs[i].neg);
    end

    // A valid word during SHIFT is ignored. A word in the done cycle is taken.
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 8'h05;
    exp_q.push_back({1'b0, 12'h005});
    @(posedge clk);
    @(negedge clk);
    i_data = 8'h10;
    wait_done(k, bad_ready, bad_hold);
    check("b2b_latency1", 64'(k), 64'd8);
    check("b2b_hold1", 64'(bad_hold), 64'd0);
    check("b2b_ready_in_done", 64'(o_ready), 64'd1);
    last_bcd = 12'h005;
    last_neg = 1'b0;
    i_data = 8'hF6;
    exp_q.push_back({1'b1, 12'h010});
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    check("b2b_accepted", 64'(o_ready), 64'd0);
    wait_done(k, bad_ready, bad_hold);
    check("b2b_latency2", 64'(k), 64'd8);
    check("b2b_hold2", 64'(bad_hold), 64'd0);
    last_bcd = 12'h010;
    last_neg = 1'b1;

    // Asynchronous reset in the middle of a conversion of 8'h64.
    @(negedge clk);
    check("pre_reset_neg", 64'(o_neg), 64'd1);
    i_valid = 1'b1;
    i_data  = 8'h64;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(o_ready), 64'd1);
    check("arst_done", 64'(o_done), 64'd0);
    check("arst_neg", 64'(o_neg), 64'd0);
    check("arst_bcd", 64'(o_bcd), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_bcd = 12'h000;
    last_neg = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (o_done) seen = 1'b1;
    end
    check("no_done_after_reset", 64'(seen), 64'd0);
    run_vec(8'h64, 12'h100, 1'b0);

    // Unsigned and wide instances.
    run_uns(8'hFF, 12'h255);
    run_uns(8'h80, 12'h128);
    run_wide(16'h8000, 20'h32768, 1'b1);
    run_wide(16'h2710, 20'h10000, 1'b0);
`ifdef BCD_ZERO_BLANK_EN
    check("wide_blank", 64'(w_blank), 64'd0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog, in case a wait never completes.
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
